iq_mag_sq_avg: RTL and testbench

- Upstream feeder for the square-root pipeline in the magnitude path of the DSP chain.
- Takes signed I/Q samples with a valid strobe and computes I²+Q² in a 3-stage pipeline.
- Optionally block-averages 2^LOG2_AVG results, then holds the unsigned result on x_out to drive the sqrt input.
- Generates a valid strobe delayed by the sqrt pipeline latency, so the consumer knows which sqrt output cycle belongs to which result.

---
 rtl/iq_mag_sq_avg.sv | 204 ++++++++++++++++++++
 tb/tb_iq_mag_sq_avg.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/iq_mag_sq_avg.sv
`timescale 1ns/1ps
// Purpose : I^2+Q^2 power of signed I/Q samples, optionally block-averaged over 2^LOG2_AVG results, held on x_out for a sqrt pipeline.
// Latency : x_valid pulses 4 clocks after the accept edge of the last sample of a block; sqrt_valid follows x_valid by SQRT_LAT clocks.
// Backpressure: none; every in_valid sample is consumed unless hit by clr or reset.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   clr              synchronous clear of pipeline valids, accumulator, block count and sqrt delay line (x_out is kept)
//   in_valid         i_in/q_in carry a sample this cycle
//   i_in, q_in       signed IN_W-bit in-phase / quadrature samples
//   x_out            averaged power, zero-extended to BITS, held between updates
//   x_valid          one-cycle pulse when x_out takes a new value
//   sqrt_valid       x_valid delayed by SQRT_LAT clocks
//   blk_cnt          number of results accumulated in the current block
module iq_mag_sq_avg #(
    parameter int IN_W     = 16,
    parameter int BITS     = 32,
    parameter int LOG2_AVG = 0,
    parameter int SQRT_LAT = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                in_valid,
    input  logic [IN_W-1:0]     i_in,
    input  logic [IN_W-1:0]     q_in,
    output logic [BITS-1:0]     x_out,
    output logic                x_valid,
    output logic                sqrt_valid,
    output logic [LOG2_AVG:0]   blk_cnt
);

    localparam int SQ_W  = 2 * IN_W;
    localparam int ACC_W = SQ_W + LOG2_AVG;
    localparam int CNT_W = LOG2_AVG + 1;
    localparam int N     = 1 << LOG2_AVG;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    // ------------------------------------------------------------------
    // Input capture: the edge at which in_valid is sampled is the accept
    // edge. A sample presented on a clr edge is dropped here.
    // ------------------------------------------------------------------
    logic            in_vld_q;
    logic [IN_W-1:0] i_q;
    logic [IN_W-1:0] q_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_vld_q <= 1'b0;
            i_q      <= '0;
            q_q      <= '0;
        end else begin
            in_vld_q <= in_valid & ~clr;
            i_q      <= i_in;
            q_q      <= q_in;
        end
    end

    // ------------------------------------------------------------------
    // S1: magnitudes. Squaring the absolute value gives the same result as
    // a signed square and lets S2 use an unsigned multiplier. The two's
    // complement negation of the most negative value, read as unsigned,
    // is exactly 2^(IN_W-1), so no extra bit is needed.
    // ------------------------------------------------------------------
    logic            s1_vld;
    logic [IN_W-1:0] s1_ai;
    logic [IN_W-1:0] s1_aq;
    logic [IN_W-1:0] i_abs;
    logic [IN_W-1:0] q_abs;

    always_comb begin
        i_abs = i_q;
        q_abs = q_q;
        if (i_q[IN_W-1]) i_abs = ~i_q + IN_W'(1);
        if (q_q[IN_W-1]) q_abs = ~q_q + IN_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld <= 1'b0;
            s1_ai  <= '0;
            s1_aq  <= '0;
        end else begin
            s1_vld <= in_vld_q & ~clr;
            s1_ai  <= i_abs;
            s1_aq  <= q_abs;
        end
    end

    // ------------------------------------------------------------------
    // S2: squares, each SQ_W bits unsigned.
    // ------------------------------------------------------------------
    logic            s2_vld;
    logic [SQ_W-1:0] s2_sq_i;
    logic [SQ_W-1:0] s2_sq_q;
    logic [SQ_W-1:0] ai_ext;
    logic [SQ_W-1:0] aq_ext;

    assign ai_ext = SQ_W'(s1_ai);
    assign aq_ext = SQ_W'(s1_aq);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_vld  <= 1'b0;
            s2_sq_i <= '0;
            s2_sq_q <= '0;
        end else begin
            s2_vld  <= s1_vld & ~clr;
            s2_sq_i <= ai_ext * ai_ext;
            s2_sq_q <= aq_ext * aq_ext;
        end
    end

    // ------------------------------------------------------------------
    // S3: sum. The largest possible sum is 2^(SQ_W-1) (both inputs at the
    // most negative value), so the SQ_W-bit adder never carries out.
    // ------------------------------------------------------------------
    logic            s3_vld;
    logic [SQ_W-1:0] s3_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_vld <= 1'b0;
            s3_sum <= '0;
        end else begin
            s3_vld <= s2_vld & ~clr;
            s3_sum <= s2_sq_i + s2_sq_q;
        end
    end

    // ------------------------------------------------------------------
    // Block accumulator. ACC_W holds N maximal sums without overflow; the
    // shift by LOG2_AVG brings the average back into SQ_W bits.
    // ------------------------------------------------------------------
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_sum;
    logic [SQ_W-1:0]  avg;
    logic [BITS-1:0]  x_nxt;

    assign acc_sum = acc + ACC_W'(s3_sum);
    assign avg     = SQ_W'(acc_sum >> LOG2_AVG);

    always_comb begin
        x_nxt            = '0;
        x_nxt[SQ_W-1:0]  = avg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            blk_cnt <= '0;
            x_out   <= '0;
            x_valid <= 1'b0;
        end else begin
            x_valid <= 1'b0;
            if (clr) begin
                // x_out deliberately keeps its last value across clr.
                acc     <= '0;
                blk_cnt <= '0;
            end else if (s3_vld) begin
                if (blk_cnt == LAST) begin
                    x_out   <= x_nxt;
                    x_valid <= 1'b1;
                    acc     <= '0;
                    blk_cnt <= '0;
                end else begin
                    acc     <= acc_sum;
                    blk_cnt <= blk_cnt + CNT_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // sqrt_valid: x_valid through a SQRT_LAT-deep shift register, so the
    // consumer can tag the sqrt result that belongs to each x_out update.
    // ------------------------------------------------------------------
    generate
        if (SQRT_LAT == 1) begin : g_dl1
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sqrt_valid <= 1'b0;
                end else begin
                    sqrt_valid <= x_valid & ~clr;
                end
            end
        end else begin : g_dln
            logic [SQRT_LAT-1:0] dl;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dl <= '0;
                end else if (clr) begin
                    dl <= '0;
                end else begin
                    dl <= {dl[SQRT_LAT-2:0], x_valid};
                end
            end

            assign sqrt_valid = dl[SQRT_LAT-1];
        end
    endgenerate

endmodule

// File: tb/tb_iq_mag_sq_avg.sv
`timescale 1ns/1ps
// Bench for iq_mag_sq_avg: two instances (no averaging and 4-sample
// averaging) share one stimulus stream. A block-average reference model
// pushes expected (edge, value) results; negedge monitors pop and compare.
module tb_iq_mag_sq_avg;

    localparam int LAT = 12;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] i_in = '0;
    logic [15:0] q_in = '0;

    logic [31:0] x0;
    logic        xv0;
    logic        sv0;
    logic [0:0]  bc0;
    logic [35:0] x2;
    logic        xv2;
    logic        sv2;
    logic [2:0]  bc2;

    always #5 clk = ~clk;

    iq_mag_sq_avg #(.IN_W(16), .BITS(32), .LOG2_AVG(0), .SQRT_LAT(LAT)) u0 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid),
        .i_in(i_in), .q_in(q_in), .x_out(x0), .x_valid(xv0),
        .sqrt_valid(sv0), .blk_cnt(bc0)
    );

    iq_mag_sq_avg #(.IN_W(16), .BITS(36), .LOG2_AVG(2), .SQRT_LAT(LAT)) u2 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid),
        .i_in(i_in), .q_in(q_in), .x_out(x2), .x_valid(xv2),
        .sqrt_valid(sv2), .blk_cnt(bc2)
    );

    typedef struct {
        int     e;
        longint v;
    } exp_t;

    exp_t   xq [2][$];
    int     sq [2][$];
    longint part_sum [2];
    int     part_cnt [2];
    longint last_x [2];
    int     bc_exp [int];
    int     edge_no = 0;
    int     checks = 0;
    int     errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, req, edge_no);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (edge %0d)", name, edge_no);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            xq[k].delete();
            sq[k].delete();
            part_sum[k] = 0;
            part_cnt[k] = 0;
            last_x[k]   = 0;
        end
    endtask

    // Reference: block average of i^2+q^2 over 2^l2 accepted samples,
    // reported 4 edges after the last sample and again LAT edges later.
    // clr at edge c kills the partial block and anything due at or after c.
    task automatic model_edge(input logic v, input int i, input int q, input logic c);
        exp_t x;
        if (!rst_n) return;
        for (int k = 0; k < 2; k++) begin
            int l2;
            l2 = (k == 0) ? 0 : 2;
            if (c) begin
                part_sum[k] = 0;
                part_cnt[k] = 0;
                while (xq[k].size() > 0 && xq[k][$].e >= edge_no) void'(xq[k].pop_back());
                while (sq[k].size() > 0 && sq[k][$] >= edge_no) void'(sq[k].pop_back());
            end else if (v) begin
                part_sum[k] += longint'(i) * longint'(i) + longint'(q) * longint'(q);
                part_cnt[k]++;
                if (part_cnt[k] == (1 << l2)) begin
                    x.e = edge_no + 4;
                    x.v = part_sum[k] >> l2;
                    xq[k].push_back(x);
                    sq[k].push_back(edge_no + 4 + LAT);
                    part_sum[k] = 0;
                    part_cnt[k] = 0;
                end
            end
        end
    endtask

    // Inputs change 1 time unit after a posedge, never on it.
    task automatic drive(input logic v, input int i, input int q, input logic c);
        in_valid = v;
        i_in     = 16'(i);
        q_in     = 16'(q);
        clr      = c;
        @(posedge clk);
        edge_no++;
        model_edge(v, i, q, c);
        #1;
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) drive(1'b0, 0, 0, 1'b0);
    endtask

    task automatic mon(input int k, input logic [63:0] xo, input logic xv, input logic sv,
                       input logic [63:0] bc);
        exp_t x;
        int   se;
        if (!rst_n) begin
            chk($sformatf("lane%0d reset x_out", k), xo, 0);
            chk($sformatf("lane%0d reset x_valid", k), 64'(xv), 0);
            chk($sformatf("lane%0d reset sqrt_valid", k), 64'(sv), 0);
            chk($sformatf("lane%0d reset blk_cnt", k), bc, 0);
            return;
        end
        if (xv) begin
            if (xq[k].size() == 0) begin
                fail_now($sformatf("lane%0d unexpected x_valid", k));
            end else begin
                x = xq[k].pop_front();
                chk($sformatf("lane%0d x_valid edge", k), 64'(edge_no), 64'(x.e));
                chk($sformatf("lane%0d x_out", k), xo, x.v);
                last_x[k] = x.v;
            end
        end else begin
            chk($sformatf("lane%0d x_out hold", k), xo, last_x[k]);
            if (xq[k].size() > 0 && xq[k][0].e <= edge_no) begin
                fail_now($sformatf("lane%0d missing x_valid", k));
                void'(xq[k].pop_front());
            end
        end
        if (sv) begin
            if (sq[k].size() == 0) begin
                fail_now($sformatf("lane%0d unexpected sqrt_valid", k));
            end else begin
                se = sq[k].pop_front();
                chk($sformatf("lane%0d sqrt_valid edge", k), 64'(edge_no), 64'(se));
            end
        end else if (sq[k].size() > 0 && sq[k][0] <= edge_no) begin
            fail_now($sformatf("lane%0d missing sqrt_valid", k));
            void'(sq[k].pop_front());
        end
    endtask

    always @(negedge clk) begin
        mon(0, 64'(x0), xv0, sv0, 64'(bc0));
        mon(1, 64'(x2), xv2, sv2, 64'(bc2));
        if (rst_n && bc_exp.exists(edge_no))
            chk("avg4 blk_cnt", 64'(bc2), 64'(bc_exp[edge_no]));
    end

    task automatic check_all_zero(input string tag);
        chk({tag, " x_out0"}, 64'(x0), 0);
        chk({tag, " x_valid0"}, 64'(xv0), 0);
        chk({tag, " sqrt_valid0"}, 64'(sv0), 0);
        chk({tag, " x_out2"}, 64'(x2), 0);
        chk({tag, " x_valid2"}, 64'(xv2), 0);
        chk({tag, " sqrt_valid2"}, 64'(sv2), 0);
        chk({tag, " blk_cnt2"}, 64'(bc2), 0);
    endtask

    initial begin
        int               s;
        logic [31:0]      r;
        logic signed [15:0] ri;
        logic signed [15:0] rq;

        model_reset();
        #23;
        rst_n = 1'b1;
        idle(3);

        // Single sample 3,4 -> 25 exactly 4 edges after acceptance.
        drive(1'b1, 3, 4, 1'b0);
        idle(4);
        chk("3,4 x_valid at t+4", 64'(xv0), 1);
        chk("3,4 x_out", 64'(x0), 25);
        idle(LAT + 2);

        // Extremes.
        drive(1'b1, -32768, -32768, 1'b0);
        idle(4);
        chk("min,min x_out", 64'(x0), 64'h8000_0000);
        drive(1'b1, 32767, -32768, 1'b0);
        idle(4);
        chk("max,min x_out", 64'(x0), 64'h7FFF_0001);

        // Averaging with gaps: fresh block, 2 idle cycles between samples.
        drive(1'b0, 0, 0, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, k, 0, 1'b0);
            bc_exp[edge_no + 4] = k & 3;
            s = edge_no;
            if (k < 4) idle(2);
        end
        idle(4);
        chk("avg4 x_valid", 64'(xv2), 1);
        chk("avg4 x_out 30>>2", 64'(x2), 7);
        idle(LAT + 2);

        // Back-to-back stream k=0..9.
        for (int k = 0; k < 10; k++) drive(1'b1, k, 0, 1'b0);
        idle(LAT + 8);

        // clr while in_valid, then 4 samples of (2,2).
        drive(1'b1, 100, 7, 1'b0);
        drive(1'b1, -50, 9, 1'b0);
        drive(1'b1, 300, 300, 1'b1);
        for (int k = 0; k < 4; k++) drive(1'b1, 2, 2, 1'b0);
        idle(4);
        chk("clr avg4 x_valid", 64'(xv2), 1);
        chk("clr avg4 x_out", 64'(x2), 8);
        idle(LAT + 2);

        // Random traffic with occasional clr.
        for (int n = 0; n < 800; n++) begin
            r  = $urandom;
            ri = r[15:0];
            r  = $urandom;
            rq = r[15:0];
            s  = int'($urandom_range(0, 99));
            drive(s < 70, int'(ri), int'(rq), s >= 98);
        end

        // Async reset mid-block with sqrt_valid bits in flight.
        for (int k = 0; k < 6; k++) drive(1'b1, k + 1, k + 2, 1'b0);
        idle(2);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async reset");
        model_reset();
        @(posedge clk);
        #1;
        drive(1'b0, 0, 0, 1'b0);
        #2;
        rst_n = 1'b1;
        idle(LAT + 10);

        drive(1'b1, 5, 12, 1'b0);
        idle(4);
        chk("post-reset x_out", 64'(x0), 169);
        idle(LAT + 6);

        for (int k = 0; k < 2; k++) begin
            chk($sformatf("lane%0d x queue drained", k), 64'(xq[k].size()), 0);
            chk($sformatf("lane%0d sqrt queue drained", k), 64'(sq[k].size()), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
